rf_scoreboard: RTL

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_busy_tracker.sv | 48 ++++
 rtl/rf_scoreboard.sv | 90 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and width helper for the register-file scoreboard.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_busy_tracker.sv
// Pending-write tracker: one busy bit per register plus a running pending count.
module rf_busy_tracker
  import rf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = aw_of(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_iss_wen,
  input  logic [AW-1:0]    i_iss_rd,
  input  logic             i_rd_wen,
  input  logic [AW-1:0]    i_rd_waddr,
  output logic [DEPTH-1:0] o_busy,
  output logic [AW:0]      o_pend_cnt
);

  logic             iss_ok;
  logic             wb_ok;
  logic             set_new;
  logic             clr_eff;
  logic [DEPTH-1:0] busy_nxt;

  always_comb begin
    iss_ok   = i_iss_wen && (i_iss_rd != '0);
    wb_ok    = i_rd_wen && (i_rd_waddr != '0);
    set_new  = iss_ok && !o_busy[i_iss_rd];
    // a clear only counts when the same-cycle issue isn't re-setting that bit
    clr_eff  = wb_ok && o_busy[i_rd_waddr] && !(iss_ok && (i_iss_rd == i_rd_waddr));
    busy_nxt = o_busy;
    if (wb_ok)  busy_nxt[i_rd_waddr] = 1'b0;
    if (iss_ok) busy_nxt[i_iss_rd]   = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy     <= '0;
      o_pend_cnt <= '0;
    end else begin
      o_busy <= busy_nxt;
      if (set_new && !clr_eff)
        o_pend_cnt <= o_pend_cnt + (AW+1)'(1);
      else if (clr_eff && !set_new)
        o_pend_cnt <= o_pend_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Two-read / one-write register file with pending-write scoreboard and optional writeback bypass.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter bit BYPASS_EN = 1'b0,
  localparam int AW = aw_of(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [AW-1:0]   i_rs1_raddr,
  output logic [XLEN-1:0] o_rs1_rdata,
  output logic            o_rs1_busy,
  input  logic [AW-1:0]   i_rs2_raddr,
  output logic [XLEN-1:0] o_rs2_rdata,
  output logic            o_rs2_busy,
  input  logic            i_iss_wen,
  input  logic [AW-1:0]   i_iss_rd,
  input  logic            i_rd_wen,
  input  logic [AW-1:0]   i_rd_waddr,
  input  logic [XLEN-1:0] i_rd_wdata,
  output logic            o_hazard,
  output logic [AW:0]     o_pend_cnt
);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] busy;

  rf_busy_tracker #(.DEPTH(DEPTH)) u_busy (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_iss_wen  (i_iss_wen),
    .i_iss_rd   (i_iss_rd),
    .i_rd_wen   (i_rd_wen),
    .i_rd_waddr (i_rd_waddr),
    .o_busy     (busy),
    .o_pend_cnt (o_pend_cnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_rd_wen && (i_rd_waddr != '0)) begin
      mem[i_rd_waddr] <= i_rd_wdata;
    end
  end

  logic wb_ok;
  logic rs1_wb_hit, rs1_iss_hit;
  logic rs2_wb_hit, rs2_iss_hit;

  always_comb begin
    wb_ok       = BYPASS_EN && i_rd_wen && (i_rd_waddr != '0);
    rs1_wb_hit  = wb_ok && (i_rd_waddr == i_rs1_raddr);
    rs2_wb_hit  = wb_ok && (i_rd_waddr == i_rs2_raddr);
    rs1_iss_hit = i_iss_wen && (i_iss_rd == i_rs1_raddr);
    rs2_iss_hit = i_iss_wen && (i_iss_rd == i_rs2_raddr);

    o_rs1_rdata = '0;
    o_rs1_busy  = 1'b0;
    if (i_rs1_raddr != '0) begin
      o_rs1_rdata = mem[i_rs1_raddr];
      o_rs1_busy  = busy[i_rs1_raddr];
      // a colliding issue keeps the register pending, so no forwarding then
      if (rs1_wb_hit && rs1_iss_hit) begin
        o_rs1_busy = 1'b1;
      end else if (rs1_wb_hit) begin
        o_rs1_rdata = i_rd_wdata;
        o_rs1_busy  = 1'b0;
      end
    end

    o_rs2_rdata = '0;
    o_rs2_busy  = 1'b0;
    if (i_rs2_raddr != '0) begin
      o_rs2_rdata = mem[i_rs2_raddr];
      o_rs2_busy  = busy[i_rs2_raddr];
      if (rs2_wb_hit && rs2_iss_hit) begin
        o_rs2_busy = 1'b1;
      end else if (rs2_wb_hit) begin
        o_rs2_rdata = i_rd_wdata;
        o_rs2_busy  = 1'b0;
      end
    end

    o_hazard = o_rs1_busy || o_rs2_busy;
  end

endmodule
